// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the fifo drain block: state encoding, buffer depth
// and default widths.
package fifo_drain_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;
  localparam int BUF_DEPTH = 3;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_drain_if.sv
// Fifo read side plus downstream valid/ready side of the drain block.
interface fifo_drain_if
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             EMPTY;
  logic [WIDTH-1:0] dataIn;
  logic             rd;
  logic [WIDTH-1:0] outData;
  logic             outValid;
  logic             outReady;

  modport master (
    input  EMPTY,
    input  dataIn,
    input  outReady,
    output rd,
    output outData,
    output outValid
  );

  modport slave (
    output EMPTY,
    output dataIn,
    output outReady,
    input  rd,
    input  outData,
    input  outValid
  );

endinterface

// File: rtl/drain_buf.sv
// Small in-order shift buffer; entry 0 is always the oldest word and entries
// at or above occ are kept at zero.
module drain_buf
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_p0 [BUF_DEPTH];
  logic [OCC_W-1:0] wr_idx;

  // A simultaneous pop shifts everything down, so the new word lands one lower.
  always_comb begin
    wr_idx = occ;
    if (pop) wr_idx = occ - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_p0[i] <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < BUF_DEPTH - 1; i++) mem_p0[i] <= mem_p0[i+1];
        mem_p0[BUF_DEPTH-1] <= '0;
      end
      if (push) mem_p0[wr_idx] <= push_data;
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign head_data = mem_p0[0];

endmodule

// File: rtl/fifo_drain.sv
// Drains an upstream one-cycle-latency fifo into a valid/ready stream, with
// credit-based read issue, a delivered-word counter and a running XOR.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  fifo_drain_if.master      bus,
  output logic [CNT_W-1:0]  wordCount,
  output logic [WIDTH-1:0]  checksum,
  output logic              busy
);

  localparam int PEND_W = OCC_W + 1;

  state_t             state;
  logic               inflight_p0;
  logic [OCC_W-1:0]   occ;
  logic [WIDTH-1:0]   head;
  logic [PEND_W-1:0]  pending;
  logic               hs;

  // Words already committed to the buffer: stored plus the one still on the fifo bus.
  assign pending = PEND_W'(occ) + PEND_W'(inflight_p0);

  assign bus.rd       = !rst && (state == RUN) && !bus.EMPTY &&
                        (pending < PEND_W'(BUF_DEPTH));
  assign bus.outValid = (occ != '0);
  assign bus.outData  = head;
  assign hs           = bus.outValid && bus.outReady;
  assign busy         = (state != IDLE);

  drain_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_p0),
    .push_data (bus.dataIn),
    .pop       (hs),
    .occ       (occ),
    .head_data (head)
  );

  // Stage p0: fifo read strobe delayed to line up with its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      inflight_p0 <= 1'b0;
      wordCount   <= '0;
      checksum    <= '0;
    end else begin
      inflight_p0 <= bus.rd;
      if (hs) begin
        wordCount <= wordCount + 1'b1;
        checksum  <= checksum ^ bus.outData;
      end
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= (pending != '0) ? FLUSH : IDLE;
        FLUSH: begin
          if (en)                   state <= RUN;
          else if (pending == '0)   state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 Parameter WIDTH, default 32, data word width; matches the fifo data width.
REQ-002 Parameter CNT_W, default 16, width of the delivered-word counter.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port en  input  1  enable; high permits new fifo reads.
REQ-006 Port EMPTY  input  1  fifo empty flag, driven by the upstream fifo.
REQ-007 Port dataIn  input  WIDTH  fifo read data, driven by the fifo dataOut.
REQ-008 Port rd  output  1  fifo read strobe, drives the fifo rd.
REQ-009 Port outData  output  WIDTH  delivered word.
REQ-010 Port outValid  output  1  outData holds a valid word.
REQ-011 Port outReady  input  1  downstream accepts the word this cycle.
REQ-012 Port wordCount  output  CNT_W  count of words handed off.
REQ-013 Port checksum  output  WIDTH  running XOR of words handed off.
REQ-014 Port busy  output  1  high in any state other than IDLE.

Function
REQ-015 The fifo read latency SHALL be one cycle: rd high in cycle k means dataIn is valid in cycle k+1 and is captured at the end of k+1.
REQ-016 An inflight register SHALL equal rd delayed by one cycle.
REQ-017 A 3-entry in-order buffer SHALL hold captured words; bufOcc ranges 0..3.
REQ-018 rd SHALL be a function of registered state and EMPTY only: rd = (state==RUN) && !EMPTY && (bufOcc + inflight < 3). rd SHALL NOT depend on outReady.
REQ-019 outValid SHALL be (bufOcc != 0); outData SHALL be the oldest buffered word.
REQ-020 A handshake SHALL occur when outValid && outReady. On a handshake the oldest word pops, wordCount increments, and checksum ^= outData.
REQ-021 While outValid && !outReady, outData SHALL hold stable.
REQ-022 Words SHALL be delivered in fifo order with no loss or duplication.
REQ-023 A capture and a pop in the same cycle SHALL leave bufOcc unchanged.
REQ-024 With outReady held high and EMPTY low, throughput SHALL be one word per cycle.
REQ-025 wordCount SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-026 FSM states and transitions:
- IDLE: go to RUN when en=1.
- RUN: go to FLUSH when en=0 and bufOcc+inflight>0; go to IDLE when en=0 and bufOcc+inflight==0.
- FLUSH: issues no rd; go to RUN when en=1; go to IDLE when bufOcc+inflight==0.
REQ-027 In FLUSH, buffered and in-flight words SHALL still be delivered.
REQ-028 EMPTY rising while a read is in flight SHALL NOT cancel capture of that word.

Reset
REQ-029 While rst=1 at a rising edge, the following SHALL clear to IDLE/zero: state, bufOcc, inflight, wordCount, checksum, and buffer contents.
REQ-030 Outputs in the cycle after reset: rd=0, outValid=0, outData=0, busy=0, wordCount=0, checksum=0.
REQ-031 A reset asserted mid-operation SHALL discard buffered and in-flight words; a fifo word popped in that cycle is lost by design.
REQ-032 rd SHALL be 0 in every cycle where rst=1.

Structure
REQ-033 A shared package fifo_drain_pkg SHALL hold the state encoding (IDLE, RUN, FLUSH), BUF_DEPTH=3, and the WIDTH and CNT_W defaults.
REQ-034 The 3-entry buffer SHALL be a sub-module, drain_buf, with push/pop/occupancy ports; the FSM, credit logic, counter and checksum stay in fifo_drain.
REQ-035 Target RTL size: 120-400 lines total.

Verification
REQ-036 Basic stream: fifo loaded with 0x0..0x4, en=1, outReady=1. Required: rd high for 5 consecutive cycles; outValid first high 2 cycles after the first rd; outData = 0,1,2,3,4 on consecutive cycles; wordCount=5; checksum=0x4.
REQ-037 Backpressure: same load, outReady=0. Required: exactly 3 rd pulses, then rd=0; outData holds 0x0. Release outReady: remaining words follow in order.
REQ-038 Empty: EMPTY=1, en=1 for 10 cycles. Required: rd=0 and outValid=0 throughout; busy=1.
REQ-039 Flush: en drops after the second rd, with outReady=1. Required: no further rd; 2 words delivered; state goes FLUSH then IDLE; busy falls.
REQ-040 Reset mid-stream: rst=1 for one cycle with bufOcc=2. Required: next cycle outValid=0, wordCount=0, checksum=0, rd=0.
REQ-041 Wrap: 65536 handshakes with CNT_W=16. Required: wordCount returns to 0x0000.
